// File: rtl/mux41_rr_sched_if.sv
// Requester/consumer bundle for the shared 4:1 datapath scheduler.
// The driver side (requesters and consumer) uses master; the scheduler uses slave.
interface mux41_rr_sched_if #(
   parameter int W = 4
);
   logic [3:0]   req;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] c;
   logic [W-1:0] d;
   logic [1:0]   sel;
   logic [3:0]   gnt;
   logic [W-1:0] y;
   logic         y_valid;
   logic         busy;

   modport master (
      output req, a, b, c, d,
      input  sel, gnt, y, y_valid, busy
   );

   modport slave (
      input  req, a, b, c, d,
      output sel, gnt, y, y_valid, busy
   );
endinterface

// File: rtl/mux41_rr_sched.sv
// Round-robin scheduler sharing one W-bit 4:1 mux among four requesters,
// with a bounded grant length and a registered output beat.
module mux41_rr_sched #(
   parameter int W        = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   mux41_rr_sched_if.slave   bus
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [1:0]         last_q, last_d;
   logic [3:0]         gnt_q, gnt_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [W-1:0]       y_q, y_d;
   logic               yv_q, yv_d;

   logic [3:0][W-1:0]  din;
   logic               hit, expire, rel, arb_now;
   logic [1:0]         arb_ptr;
   logic [2:0]         pick;

   // Returns {found, index}: first set request after ptr, ptr itself searched last.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (r[idx] && !rr_pick[2]) rr_pick = {1'b1, idx};
      end
   endfunction

   assign din     = {bus.d, bus.c, bus.b, bus.a};
   assign hit     = bus.req[sel_q];
   assign expire  = (cnt_q == 4'(HOLD_MAX));
   assign rel     = (state_q == S_GRANT) && (!hit || expire);
   assign arb_now = (state_q == S_IDLE) || rel;
   // On release the pointer moves to sel this very edge, so arbitrate from sel directly.
   assign arb_ptr = (state_q == S_GRANT) ? sel_q : last_q;
   assign pick    = rr_pick(bus.req, arb_ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= 2'd0;
         last_q  <= 2'd3;
         gnt_q   <= 4'd0;
         cnt_q   <= 4'd0;
         y_q     <= '0;
         yv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick[2]) state_d = S_GRANT;
         S_GRANT: if (rel && !pick[2]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sel_d  = sel_q;
      last_d = last_q;
      gnt_d  = gnt_q;
      cnt_d  = cnt_q;
      y_d    = y_q;
      yv_d   = 1'b0;
      if (state_q == S_GRANT) begin
         if (hit) begin
            y_d  = din[sel_q];
            yv_d = 1'b1;
         end
         if (rel) last_d = sel_q;
         else     cnt_d  = cnt_q + 4'd1;
      end
      if (arb_now) begin
         if (pick[2]) begin
            sel_d = pick[1:0];
            gnt_d = 4'b0001 << pick[1:0];
            cnt_d = 4'd1;
         end else begin
            gnt_d = 4'd0;
         end
      end
   end

   assign bus.sel     = sel_q;
   assign bus.gnt     = gnt_q;
   assign bus.y       = y_q;
   assign bus.y_valid = yv_q;
   assign bus.busy    = |gnt_q;

endmodule

// File: tb/tb_mux41_rr_sched.sv
// Directed bench: table of per-cycle vectors on a HOLD_MAX=4 instance,
// plus a hand-written alternation sequence on a HOLD_MAX=1 instance.
module tb_mux41_rr_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux41_rr_sched_if #(.W(4)) bus4 ();
   mux41_rr_sched_if #(.W(4)) bus1 ();

   mux41_rr_sched #(.W(4), .HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
   mux41_rr_sched #(.W(4), .HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   // Inputs applied during one cycle, outputs expected after the following edge.
   typedef struct {
      logic       r;
      logic [3:0] req;
      logic [3:0] a;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic [3:0] y;
      logic       yv;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic r, input logic [3:0] req, input logic [3:0] a,
                      input logic [3:0] gnt, input logic [1:0] sel,
                      input logic [3:0] y, input logic yv);
      vec_t v;
      v = '{r, req, a, gnt, sel, y, yv};
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      int g;
      int yy;
      bus4.req = 4'd0; bus4.a = 4'd0; bus4.b = 4'd2; bus4.c = 4'd3; bus4.d = 4'd4;
      bus1.req = 4'd0; bus1.a = 4'd1; bus1.b = 4'd2; bus1.c = 4'd3; bus1.d = 4'd4;

      // reset and idle
      add(1, 4'b0000, 4'h0, 4'b0000, 2'd0, 4'h0, 0);
      add(1, 4'b0000, 4'h0, 4'b0000, 2'd0, 4'h0, 0);
      for (int i = 0; i < 10; i++) add(0, 4'b0000, 4'h0, 4'b0000, 2'd0, 4'h0, 0);

      // single requester: expiry re-grants without a gap
      add(0, 4'b0001, 4'h5, 4'b0001, 2'd0, 4'h0, 0);
      for (int i = 1; i < 12; i++) add(0, 4'b0001, 4'h5, 4'b0001, 2'd0, 4'h5, 1);
      add(0, 4'b0000, 4'h5, 4'b0000, 2'd0, 4'h5, 0);

      // full contention from a fresh pointer
      add(1, 4'b0000, 4'h1, 4'b0000, 2'd0, 4'h0, 0);
      for (int n = 1; n <= 20; n++) begin
         g  = ((n - 1) / 4) % 4;
         yy = (n < 2) ? 0 : ((n - 2) / 4) % 4 + 1;
         add(0, 4'b1111, 4'h1, 4'(4'b0001 << g), 2'(g), 4'(yy), n >= 2);
      end
      add(1, 4'b0000, 4'h1, 4'b0000, 2'd0, 4'h0, 0);

      // early drop of requester 2
      add(0, 4'b1100, 4'h1, 4'b0100, 2'd2, 4'h0, 0);
      add(0, 4'b1100, 4'h1, 4'b0100, 2'd2, 4'h3, 1);
      add(0, 4'b1100, 4'h1, 4'b0100, 2'd2, 4'h3, 1);
      add(0, 4'b1000, 4'h1, 4'b1000, 2'd3, 4'h3, 0);
      add(0, 4'b1000, 4'h1, 4'b1000, 2'd3, 4'h4, 1);
      add(0, 4'b1000, 4'h1, 4'b1000, 2'd3, 4'h4, 1);
      add(0, 4'b0111, 4'h1, 4'b0001, 2'd0, 4'h4, 0);
      add(0, 4'b0000, 4'h1, 4'b0000, 2'd0, 4'h4, 0);

      // reset in the middle of a requester-2 grant
      add(0, 4'b0100, 4'h1, 4'b0100, 2'd2, 4'h4, 0);
      add(0, 4'b0100, 4'h1, 4'b0100, 2'd2, 4'h3, 1);
      add(1, 4'b1010, 4'h1, 4'b0000, 2'd0, 4'h0, 0);
      add(0, 4'b1010, 4'h1, 4'b0010, 2'd1, 4'h0, 0);
      for (int i = 0; i < 3; i++) add(0, 4'b1010, 4'h1, 4'b0010, 2'd1, 4'h2, 1);
      add(0, 4'b1010, 4'h1, 4'b1000, 2'd3, 4'h2, 1);
      add(0, 4'b1010, 4'h1, 4'b1000, 2'd3, 4'h4, 1);
      add(0, 4'b0000, 4'h1, 4'b0000, 2'd3, 4'h4, 0);

      foreach (tbl[i]) begin
         rst      = tbl[i].r;
         bus4.req = tbl[i].req;
         bus4.a   = tbl[i].a;
         @(posedge clk);
         #1;
         chk("gnt",     i, 32'(bus4.gnt),     32'(tbl[i].gnt));
         chk("sel",     i, 32'(bus4.sel),     32'(tbl[i].sel));
         chk("y",       i, 32'(bus4.y),       32'(tbl[i].y));
         chk("y_valid", i, 32'(bus4.y_valid), 32'(tbl[i].yv));
         chk("busy",    i, 32'(bus4.busy),    32'(tbl[i].gnt != 4'd0));
      end

      // HOLD_MAX=1: grants alternate every cycle with a continuous beat stream
      rst      = 1'b0;
      bus1.req = 4'b0110;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         #1;
         chk("h1_gnt", n, 32'(bus1.gnt),     (n % 2 == 1) ? 32'h2 : 32'h4);
         chk("h1_yv",  n, 32'(bus1.y_valid), (n >= 2) ? 32'd1 : 32'd0);
         if (n >= 2) chk("h1_y", n, 32'(bus1.y), (n % 2 == 0) ? 32'd2 : 32'd3);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
